// File: rtl/tft_line_fetch_ctrl.sv
// Burst read scheduler and pixel FIFO feeding the TFT driver data input.
// Optional feature macro TFT_FETCH_STATS_EN adds the per-frame underflow_cnt output.
module tft_line_fetch_ctrl #(
  parameter int unsigned       H_ACTIVE  = 480,
  parameter int unsigned       V_ACTIVE  = 272,
  parameter int unsigned       BURST_LEN = 16,
  parameter int unsigned       FIFO_AW   = 6,
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 24'h0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [15:0]       pix_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [4:0]        rd_len,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              busy,
  output logic              underflow
`ifdef TFT_FETCH_STATS_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int unsigned TOTAL  = H_ACTIVE * V_ACTIVE;
  localparam int unsigned WL_RAW = $clog2(TOTAL + 1);
  localparam int unsigned WL_W   = (WL_RAW > 5) ? WL_RAW : 5;
  localparam int unsigned FS_W   = FIFO_AW + 2;

  localparam logic [WL_W-1:0]    TOTAL_WL  = WL_W'(TOTAL);
  localparam logic [WL_W-1:0]    BURST_WL  = WL_W'(BURST_LEN);
  localparam logic [4:0]         BURST_L5  = 5'(BURST_LEN);
  localparam logic [FS_W-1:0]    BURST_FS  = FS_W'(BURST_LEN);
  localparam logic [FS_W-1:0]    DEPTH_FS  = FS_W'(2 ** FIFO_AW);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ZERO  = {FIFO_AW{1'b0}};
  localparam logic [FIFO_AW:0]   CNT_ZERO  = {(FIFO_AW+1){1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SPACE = 3'd1,
    ST_REQ        = 3'd2,
    ST_XFER       = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [4:0]          rd_len_q, rd_len_d;
  logic [WL_W-1:0]     words_left_q, words_left_d;
  logic [4:0]          outstanding_q, outstanding_d;
  logic                busy_q, busy_d;
  logic                restart_pend_q, restart_pend_d;
  logic                underflow_q, underflow_d;
  logic [15:0]         pix_data_q, pix_data_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [15:0]         mem_q [2**FIFO_AW];

  logic                empty_s;
  logic                pop_s;
  logic                push_s;
  logic                last_beat_s;
  logic                restart_s;
  logic [FS_W-1:0]     free_s;

  assign empty_s     = (count_q == CNT_ZERO);
  assign pop_s       = pix_req & ~empty_s;
  // Beats of a burst interrupted by frame_start are consumed but never stored.
  assign push_s      = (state_q == ST_XFER) & rd_valid & ~restart_pend_q & ~frame_start;
  assign last_beat_s = (state_q == ST_XFER) & rd_valid & (outstanding_q == 5'd1);
  assign restart_s   = (frame_start & (state_q != ST_XFER)) |
                       (last_beat_s & (restart_pend_q | frame_start));
  assign free_s      = DEPTH_FS - FS_W'(count_q) - FS_W'(outstanding_q);

  // Fetch FSM: next state, request fields and frame bookkeeping.
  always_comb begin
    state_d        = state_q;
    rd_req_d       = rd_req_q;
    rd_addr_d      = rd_addr_q;
    rd_len_d       = rd_len_q;
    words_left_d   = words_left_q;
    outstanding_d  = outstanding_q;
    busy_d         = busy_q;
    restart_pend_d = restart_pend_q;
    case (state_q)
      ST_WAIT_SPACE: begin
        if (free_s >= BURST_FS) begin
          state_d  = ST_REQ;
          rd_req_d = 1'b1;
          rd_len_d = (words_left_q >= BURST_WL) ? BURST_L5 : words_left_q[4:0];
        end else begin
          state_d = ST_WAIT_SPACE;
        end
      end
      ST_REQ: begin
        if (rd_gnt) begin
          state_d       = ST_XFER;
          rd_req_d      = 1'b0;
          outstanding_d = rd_len_q;
        end else begin
          rd_req_d = 1'b1;
        end
      end
      ST_XFER: begin
        restart_pend_d = restart_pend_q | frame_start;
        if (last_beat_s) begin
          outstanding_d = 5'd0;
          rd_addr_d     = rd_addr_q + ADDR_W'(rd_len_q);
          words_left_d  = words_left_q - WL_W'(rd_len_q);
          if (words_left_q == WL_W'(rd_len_q)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_WAIT_SPACE;
          end
        end else if (rd_valid) begin
          outstanding_d = outstanding_q - 5'd1;
        end else begin
          outstanding_d = outstanding_q;
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = state_q;
      end
      default: begin
        state_d  = ST_IDLE;
        rd_req_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
    if (restart_s) begin
      state_d        = ST_WAIT_SPACE;
      rd_req_d       = 1'b0;
      rd_addr_d      = BASE_ADDR;
      words_left_d   = TOTAL_WL;
      outstanding_d  = 5'd0;
      busy_d         = 1'b1;
      restart_pend_d = 1'b0;
    end else begin
      restart_pend_d = restart_pend_d;
    end
  end

  // FIFO pointers, occupancy and the registered pixel output.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pix_data_d  = pix_data_q;
    underflow_d = underflow_q;
    if (restart_s) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    if (pop_s) begin
      pix_data_d = mem_q[rd_ptr_q];
    end else if (pix_req) begin
      pix_data_d = 16'h0000;
    end else begin
      pix_data_d = pix_data_q;
    end
    if (frame_start || restart_s) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q | (pix_req & empty_s);
    end
  end

  // Control and datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= ST_IDLE;
      rd_req_q       <= 1'b0;
      rd_addr_q      <= BASE_ADDR;
      rd_len_q       <= 5'd0;
      words_left_q   <= {WL_W{1'b0}};
      outstanding_q  <= 5'd0;
      busy_q         <= 1'b0;
      restart_pend_q <= 1'b0;
      underflow_q    <= 1'b0;
      pix_data_q     <= 16'h0000;
      wr_ptr_q       <= PTR_ZERO;
      rd_ptr_q       <= PTR_ZERO;
      count_q        <= CNT_ZERO;
    end else begin
      state_q        <= state_d;
      rd_req_q       <= rd_req_d;
      rd_addr_q      <= rd_addr_d;
      rd_len_q       <= rd_len_d;
      words_left_q   <= words_left_d;
      outstanding_q  <= outstanding_d;
      busy_q         <= busy_d;
      restart_pend_q <= restart_pend_d;
      underflow_q    <= underflow_d;
      pix_data_q     <= pix_data_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge Clk) begin
    if (push_s && !Rst) begin
      mem_q[wr_ptr_q] <= rd_data;
    end
  end

`ifdef TFT_FETCH_STATS_EN
  logic [15:0] ufl_cnt_q, ufl_cnt_d;

  // Saturating count of underflowing pops in the current frame.
  always_comb begin
    ufl_cnt_d = ufl_cnt_q;
    if (frame_start || restart_s) begin
      ufl_cnt_d = 16'h0000;
    end else if (pix_req && empty_s && (ufl_cnt_q != 16'hFFFF)) begin
      ufl_cnt_d = ufl_cnt_q + 16'h0001;
    end else begin
      ufl_cnt_d = ufl_cnt_q;
    end
  end

  // Statistics register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ufl_cnt_q <= 16'h0000;
    end else begin
      ufl_cnt_q <= ufl_cnt_d;
    end
  end

  assign underflow_cnt = ufl_cnt_q;
`endif

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign busy      = busy_q;
  assign underflow = underflow_q;
  assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_tft_line_fetch_ctrl.sv
// Directed bench for tft_line_fetch_ctrl using a reduced 20x5 frame (100 words:
// six 16-word bursts then one 4-word burst); memory returns data = word address.
module tb_tft_line_fetch_ctrl;

  localparam int unsigned ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              pix_req;
  logic [15:0]       pix_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [4:0]        rd_len;
  logic              rd_gnt;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              busy;
  logic              underflow;
`ifdef TFT_FETCH_STATS_EN
  logic [15:0]       underflow_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  bit mem_en = 1'b1;
  int grant_cnt = 0;
  int burst_beat = 0;
  logic [ADDR_W-1:0] req_addr_q [$];
  logic [4:0]        req_len_q [$];

  tft_line_fetch_ctrl #(
    .H_ACTIVE(20), .V_ACTIVE(5), .BURST_LEN(16), .FIFO_AW(6),
    .ADDR_W(ADDR_W), .BASE_ADDR(24'h0)
  ) dut (
    .Clk(clk), .Rst(rst), .frame_start(frame_start), .pix_req(pix_req),
    .pix_data(pix_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .underflow(underflow)
`ifdef TFT_FETCH_STATS_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: grant two cycles after a request is seen, then stream beats.
  initial begin
    logic [ADDR_W-1:0] m_addr;
    logic [4:0]        m_len;
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_en && rd_req && !rst) begin
        m_addr = rd_addr; m_len = rd_len;
        @(negedge clk);
        rd_gnt = 1'b1;
        req_addr_q.push_back(m_addr);
        req_len_q.push_back(m_len);
        grant_cnt++;
        @(negedge clk);
        rd_gnt = 1'b0;
        for (int i = 0; i < int'(m_len); i++) begin
          rd_valid = 1'b1;
          rd_data = m_addr[15:0] + 16'(i);
          burst_beat = i + 1;
          @(negedge clk);
        end
        rd_valid = 1'b0;
        burst_beat = 0;
      end
    end
  end

  // Push into a full FIFO with no pop must never happen.
  always @(posedge clk) begin
    if (!rst && dut.push_s && !dut.pop_s && (dut.count_q == 7'd64)) ovf_cnt++;
  end

  task automatic pulse_frame_start();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    checks++; if (rd_addr !== 24'h0) begin errors++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    checks++; if (rd_len !== 5'd0) begin errors++; $display("FAIL reset_rd_len: got %0d want 0", rd_len); end
    checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL reset_pix_data: got %h want 0000", pix_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if ({rd_req, busy} !== 2'b00) begin errors++; $display("FAIL idle_no_req: got req=%b busy=%b want 0 0", rd_req, busy); end
  endtask

  task automatic test_frame();
    int req_seen;
    pulse_frame_start();
    checks++; if ({busy, rd_req} !== 2'b10) begin errors++; $display("FAIL frame_start_busy: got busy=%b req=%b want 1 0", busy, rd_req); end
    repeat (120) @(negedge clk);
    checks++; if (req_addr_q.size() !== 4) begin errors++; $display("FAIL fill_burst_count: got %0d want 4", req_addr_q.size()); end
    for (int i = 0; i < 4 && i < req_addr_q.size(); i++) begin
      checks++;
      if (req_addr_q[i] !== ADDR_W'(16 * i) || req_len_q[i] !== 5'd16) begin
        errors++; $display("FAIL fill_burst_%0d: got addr=%0d len=%0d want addr=%0d len=16", i, req_addr_q[i], req_len_q[i], 16 * i);
      end
    end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL fifo_full_stall: got rd_req=%b want 0", rd_req); end
    for (int k = 0; k < 100; k++) begin
      pix_req = 1'b1;
      @(negedge clk); pix_req = 1'b0;
      checks++; if (pix_data !== 16'(k)) begin errors++; $display("FAIL pixel_%0d: got %0d want %0d", k, pix_data, k); end
      @(negedge clk);
      checks++; if (pix_data !== 16'(k)) begin errors++; $display("FAIL pixel_hold_%0d: got %0d want %0d", k, pix_data, k); end
    end
    checks++; if ({busy, underflow} !== 2'b00) begin errors++; $display("FAIL frame_end: got busy=%b underflow=%b want 0 0", busy, underflow); end
    checks++; if (req_addr_q.size() !== 7) begin errors++; $display("FAIL frame_burst_count: got %0d want 7", req_addr_q.size()); end
    if (req_addr_q.size() >= 7) begin
      checks++; if (req_addr_q[5] !== 24'd80 || req_len_q[5] !== 5'd16) begin errors++; $display("FAIL burst_6: got addr=%0d len=%0d want 80 16", req_addr_q[5], req_len_q[5]); end
      checks++; if (req_addr_q[6] !== 24'd96 || req_len_q[6] !== 5'd4) begin errors++; $display("FAIL burst_7_tail: got addr=%0d len=%0d want 96 4", req_addr_q[6], req_len_q[6]); end
    end
    req_seen = 0;
    repeat (30) begin @(negedge clk); if (rd_req) req_seen++; end
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL done_no_req: got %0d request cycles want 0", req_seen); end
  endtask

  task automatic test_underflow();
    mem_en = 1'b0;
    pulse_frame_start();
    for (int i = 0; i < 5; i++) begin
      pix_req = 1'b1;
      @(negedge clk); pix_req = 1'b0;
      checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL underflow_data_%0d: got %h want 0000", i, pix_data); end
      @(negedge clk);
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", underflow); end
`ifdef TFT_FETCH_STATS_EN
    checks++; if (underflow_cnt !== 16'd5) begin errors++; $display("FAIL underflow_cnt: got %0d want 5", underflow_cnt); end
`endif
    pulse_frame_start();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b want 0", underflow); end
`ifdef TFT_FETCH_STATS_EN
    checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL underflow_cnt_clear: got %0d want 0", underflow_cnt); end
`endif
  endtask

  task automatic test_restart();
    int g0;
    bit found;
    g0 = grant_cnt;
    pulse_frame_start();
    mem_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      if (grant_cnt == g0 + 2 && rd_valid && burst_beat == 3) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL restart_sync: got timeout want beat 3 of burst 2"); end
    @(negedge clk); frame_start = 1'b1; mem_en = 1'b0;
    @(negedge clk); frame_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rd_req) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL restart_req: got no rd_req want rd_req"); end
    checks++; if (rd_addr !== 24'h0 || rd_len !== 5'd16) begin errors++; $display("FAIL restart_addr: got addr=%0d len=%0d want 0 16", rd_addr, rd_len); end
    checks++; if ({busy, underflow} !== 2'b10) begin errors++; $display("FAIL restart_flags: got busy=%b underflow=%b want 1 0", busy, underflow); end
    pix_req = 1'b1;
    @(negedge clk); pix_req = 1'b0;
    checks++; if (pix_data !== 16'h0000 || underflow !== 1'b1) begin errors++; $display("FAIL restart_flushed: got data=%h underflow=%b want 0000 1", pix_data, underflow); end
    mem_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (grant_cnt == g0 + 3) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL restart_grant: got timeout want new grant"); end
    repeat (20) @(negedge clk);
    pix_req = 1'b1;
    @(negedge clk);
    checks++; if (pix_data !== 16'd0) begin errors++; $display("FAIL restart_pixel0: got %0d want 0", pix_data); end
    @(negedge clk); pix_req = 1'b0;
    checks++; if (pix_data !== 16'd1) begin errors++; $display("FAIL restart_pixel1: got %0d want 1", pix_data); end
  endtask

  task automatic test_rst_mid_burst();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      if (rd_valid && burst_beat == 3) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_sync: got timeout want beat 3"); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if ({rd_req, busy, underflow} !== 3'b000 || rd_addr !== 24'h0 || rd_len !== 5'd0 || pix_data !== 16'h0) begin
      errors++; $display("FAIL rst_mid_state: got req=%b busy=%b ufl=%b addr=%0d len=%0d data=%h want all zero", rd_req, busy, underflow, rd_addr, rd_len, pix_data);
    end
    repeat (20) @(negedge clk);
    checks++; if ({rd_req, busy} !== 2'b00) begin errors++; $display("FAIL rst_late_beats: got req=%b busy=%b want 0 0", rd_req, busy); end
    pix_req = 1'b1;
    @(negedge clk); pix_req = 1'b0;
    checks++; if (pix_data !== 16'h0000 || underflow !== 1'b1) begin errors++; $display("FAIL rst_fifo_empty: got data=%h underflow=%b want 0000 1", pix_data, underflow); end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_req = 1'b0;
    test_reset();
    test_frame();
    test_underflow();
    test_restart();
    test_rst_mid_burst();
    checks++; if (ovf_cnt !== 0) begin errors++; $display("FAIL fifo_overflow: got %0d pushes into full FIFO want 0", ovf_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
